// File: rtl/wb_mtimer_pkg.sv
// Shared constants for the Wishbone machine timer: register offsets,
// CTRL field layout, reset values and a byte-lane merge helper.
package wb_mtimer_pkg;

  localparam logic [2:0] ADR_MTIME_LO    = 3'd0;
  localparam logic [2:0] ADR_MTIME_HI    = 3'd1;
  localparam logic [2:0] ADR_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] ADR_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] ADR_CTRL        = 3'd4;
  localparam logic [2:0] ADR_STATUS      = 3'd5;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int PRESC_W        = 8;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Bytes whose sel bit is set take the new data, the rest keep the old value.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic is_mapped(input logic [2:0] adr);
    return adr <= ADR_STATUS;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescaler for the machine timer: counts 0..presc while enabled and
// flags the wrap cycle as a tick.
module mtimer_prescaler
  import wb_mtimer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  // ">=" lets the counter recover if presc is lowered below the running count.
  assign tick = en && (cnt >= presc);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_mtimer.sv
// Wishbone-attached RISC-V style machine timer: 64-bit mtime/mtimecmp,
// prescaled tick, atomic high-word read shadow and level interrupt.
module wb_mtimer
  import wb_mtimer_pkg::*;
#(
  parameter logic [PRESC_W-1:0] PRESC_RESET = 8'd0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [2:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        timer_irq_o
);

  logic [63:0]        mtime;
  logic [63:0]        mtime_next;
  logic [63:0]        mtimecmp;
  logic [31:0]        mtime_shadow;
  logic               ctrl_en;
  logic [PRESC_W-1:0] ctrl_presc;
  logic [31:0]        ctrl_word;
  logic [31:0]        ctrl_wdata;
  logic [31:0]        rdata;
  logic               req;
  logic               mapped;
  logic               wr;
  logic               rd;
  logic               wr_ctrl;
  logic               tick;

  // The terminate flops mask the request so a held strobe is served every other cycle.
  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign mapped  = is_mapped(wb_adr_i);
  assign wr      = req & mapped & wb_we_i;
  assign rd      = req & mapped & ~wb_we_i;
  assign wr_ctrl = wr && (wb_adr_i == ADR_CTRL);

  mtimer_prescaler u_prescaler (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .en    (ctrl_en),
    .presc (ctrl_presc),
    .clr   (wr_ctrl && (wb_sel_i != 4'b0000)),
    .tick  (tick)
  );

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_EN_BIT] = ctrl_en;
    ctrl_word[CTRL_PRESC_LSB +: PRESC_W] = ctrl_presc;
    ctrl_wdata = apply_sel(ctrl_word, wb_dat_i, wb_sel_i);
  end

  // A bus write to either mtime half takes priority over the tick increment.
  always_comb begin
    mtime_next = mtime;
    if (wr && (wb_adr_i == ADR_MTIME_LO)) begin
      mtime_next[31:0] = apply_sel(mtime[31:0], wb_dat_i, wb_sel_i);
    end else if (wr && (wb_adr_i == ADR_MTIME_HI)) begin
      mtime_next[63:32] = apply_sel(mtime[63:32], wb_dat_i, wb_sel_i);
    end else if (tick) begin
      mtime_next = mtime + 64'd1;
    end
  end

  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      ADR_MTIME_LO:    rdata = mtime[31:0];
      ADR_MTIME_HI:    rdata = mtime_shadow;
      ADR_MTIMECMP_LO: rdata = mtimecmp[31:0];
      ADR_MTIMECMP_HI: rdata = mtimecmp[63:32];
      ADR_CTRL:        rdata = ctrl_word;
      ADR_STATUS:      rdata = {31'd0, timer_irq_o};
      default:         rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mtime        <= '0;
      mtime_shadow <= '0;
      mtimecmp     <= MTIMECMP_RESET;
      ctrl_en      <= 1'b0;
      ctrl_presc   <= PRESC_RESET;
      wb_ack_o     <= 1'b0;
      wb_err_o     <= 1'b0;
      wb_dat_o     <= '0;
      timer_irq_o  <= 1'b0;
    end else begin
      mtime <= mtime_next;
      if (wr && (wb_adr_i == ADR_MTIMECMP_LO)) begin
        mtimecmp[31:0] <= apply_sel(mtimecmp[31:0], wb_dat_i, wb_sel_i);
      end
      if (wr && (wb_adr_i == ADR_MTIMECMP_HI)) begin
        mtimecmp[63:32] <= apply_sel(mtimecmp[63:32], wb_dat_i, wb_sel_i);
      end
      if (wr_ctrl) begin
        ctrl_en    <= ctrl_wdata[CTRL_EN_BIT];
        ctrl_presc <= ctrl_wdata[CTRL_PRESC_LSB +: PRESC_W];
      end
      // Freezing the upper half here makes a LO-then-HI read pair coherent.
      if (rd && (wb_adr_i == ADR_MTIME_LO)) begin
        mtime_shadow <= mtime[63:32];
      end
      wb_ack_o    <= req & mapped;
      wb_err_o    <= req & ~mapped;
      wb_dat_o    <= rd ? rdata : 32'd0;
      timer_irq_o <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_wb_mtimer.sv
// Directed self-checking bench for wb_mtimer: register map, prescaled
// counting, atomic reads, interrupt timing, byte lanes and bus errors.
module tb_wb_mtimer;

  localparam logic [7:0] TB_PRESC_RESET = 8'h05;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic [2:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        timer_irq_o;

  int          check_count;
  int          pass_count;
  logic [31:0] last_dat;
  logic        last_ack;
  logic        last_err;
  logic        last_irq;
  logic        post_term;
  logic [3:0]  ack_pattern;

  wb_mtimer #(.PRESC_RESET(TB_PRESC_RESET)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_sel_i    (wb_sel_i),
    .wb_we_i     (wb_we_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .wb_err_o    (wb_err_o),
    .timer_irq_o (timer_irq_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One single-beat transfer, entered just after a rising edge; leaves one idle cycle.
  task automatic applyStimulus(input logic [2:0] adr, input logic we,
                               input logic [31:0] dat, input logic [3:0] sel);
    wb_adr_i = adr;
    wb_we_i  = we;
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    @(posedge wb_clk_i); #1;
    last_ack = wb_ack_o;
    last_err = wb_err_o;
    last_dat = wb_dat_o;
    last_irq = timer_irq_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_sel_i = 4'b0000;
    @(posedge wb_clk_i); #1;
    post_term = wb_ack_o | wb_err_o;
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    wb_rst_i = 1'b1;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_sel_i = '0;
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;

    // Reset values of the whole register map
    checkOutput("rst_irq", timer_irq_o, 0);
    applyStimulus(3'd0, 1'b0, 0, 0); checkOutput("rst_mtime_lo", last_dat, 32'h0);
    checkOutput("rst_ack", last_ack, 1);
    applyStimulus(3'd1, 1'b0, 0, 0); checkOutput("rst_mtime_hi", last_dat, 32'h0);
    applyStimulus(3'd2, 1'b0, 0, 0); checkOutput("rst_cmp_lo", last_dat, 32'hFFFF_FFFF);
    applyStimulus(3'd3, 1'b0, 0, 0); checkOutput("rst_cmp_hi", last_dat, 32'hFFFF_FFFF);
    applyStimulus(3'd4, 1'b0, 0, 0); checkOutput("rst_ctrl", last_dat, 32'h0000_0500);
    applyStimulus(3'd5, 1'b0, 0, 0); checkOutput("rst_status", last_dat, 32'h0);

    // PRESC=3: one tick per 4 cycles, sampled 40 cycles apart
    applyStimulus(3'd4, 1'b1, 32'h0000_0301, 4'hF);
    applyStimulus(3'd0, 1'b0, 0, 0);
    checkOutput("presc_ack", last_ack, 1);
    checkOutput("presc_ack_once", post_term, 0);
    checkOutput("presc_t0", last_dat, 32'd0);
    repeat (38) @(posedge wb_clk_i);
    #1;
    applyStimulus(3'd0, 1'b0, 0, 0);
    checkOutput("presc_t40", last_dat, 32'd10);

    // Carry into the upper word and coherent LO/HI read
    applyStimulus(3'd4, 1'b1, 32'h0, 4'hF);
    applyStimulus(3'd0, 1'b1, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(3'd1, 1'b1, 32'h0, 4'hF);
    applyStimulus(3'd4, 1'b1, 32'h0000_0001, 4'hF);
    applyStimulus(3'd0, 1'b0, 0, 0); checkOutput("carry_lo", last_dat, 32'h0);
    applyStimulus(3'd1, 1'b0, 0, 0); checkOutput("carry_hi", last_dat, 32'h1);
    applyStimulus(3'd4, 1'b1, 32'h0, 4'hF);
    applyStimulus(3'd0, 1'b0, 0, 0);
    applyStimulus(3'd1, 1'b1, 32'h0000_1234, 4'hF);
    applyStimulus(3'd1, 1'b0, 0, 0); checkOutput("shadow_hold", last_dat, 32'h1);
    applyStimulus(3'd0, 1'b0, 0, 0);
    applyStimulus(3'd1, 1'b0, 0, 0); checkOutput("shadow_new", last_dat, 32'h0000_1234);

    // Compare match raises the interrupt one cycle after mtime hits 0x20
    applyStimulus(3'd4, 1'b1, 32'h0, 4'hF);
    applyStimulus(3'd0, 1'b1, 32'h0, 4'hF);
    applyStimulus(3'd1, 1'b1, 32'h0, 4'hF);
    applyStimulus(3'd3, 1'b1, 32'h0, 4'hF);
    applyStimulus(3'd2, 1'b1, 32'h20, 4'hF);
    checkOutput("irq_idle", timer_irq_o, 0);
    applyStimulus(3'd4, 1'b1, 32'h0000_0001, 4'hF);
    repeat (31) @(posedge wb_clk_i);
    #1 checkOutput("irq_at_match", timer_irq_o, 0);
    @(posedge wb_clk_i);
    #1 checkOutput("irq_after_match", timer_irq_o, 1);
    applyStimulus(3'd5, 1'b0, 0, 0); checkOutput("status_irq", last_dat, 32'h1);
    applyStimulus(3'd2, 1'b1, 32'hFFFF_FFFF, 4'hF);
    checkOutput("irq_write_cycle", last_irq, 1);
    checkOutput("irq_fall", timer_irq_o, 0);

    // Single byte-lane write on a tick cycle beats the increment
    applyStimulus(3'd4, 1'b1, 32'h0, 4'hF);
    applyStimulus(3'd0, 1'b1, 32'h1122_3344, 4'hF);
    applyStimulus(3'd1, 1'b1, 32'h5566_7788, 4'hF);
    applyStimulus(3'd4, 1'b1, 32'h0000_0001, 4'hF);
    applyStimulus(3'd0, 1'b1, 32'h0000_00AB, 4'b0001);
    applyStimulus(3'd0, 1'b0, 0, 0); checkOutput("lane_lo", last_dat, 32'h1122_33AC);
    applyStimulus(3'd1, 1'b0, 0, 0); checkOutput("lane_hi", last_dat, 32'h5566_7788);

    // Unmapped offsets terminate with an error and change nothing
    applyStimulus(3'd4, 1'b1, 32'h0, 4'hF);
    applyStimulus(3'd6, 1'b1, 32'hDEAD_BEEF, 4'hF);
    checkOutput("err6_wr_err", last_err, 1);
    checkOutput("err6_wr_ack", last_ack, 0);
    checkOutput("err6_wr_once", post_term, 0);
    applyStimulus(3'd6, 1'b0, 0, 0);
    checkOutput("err6_rd_err", last_err, 1);
    checkOutput("err6_rd_dat", last_dat, 32'h0);
    applyStimulus(3'd7, 1'b0, 0, 0);
    checkOutput("err7_rd_err", last_err, 1);
    applyStimulus(3'd2, 1'b0, 0, 0); checkOutput("err_cmp_lo", last_dat, 32'hFFFF_FFFF);
    applyStimulus(3'd3, 1'b0, 0, 0); checkOutput("err_cmp_hi", last_dat, 32'h0);

    // Zero byte enables: acknowledged, nothing written
    applyStimulus(3'd3, 1'b1, 32'h1234_5678, 4'b0000);
    checkOutput("sel0_ack", last_ack, 1);
    applyStimulus(3'd3, 1'b0, 0, 0); checkOutput("sel0_cmp_hi", last_dat, 32'h0);

    // Held strobe is terminated every second cycle
    wb_adr_i = 3'd5;
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      @(posedge wb_clk_i); #1;
      ack_pattern[i] = wb_ack_o;
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    checkOutput("b2b_pattern", ack_pattern, 4'b1010);

    // Reset during a request drops the terminate and restores defaults
    wb_rst_i = 1'b1;
    wb_adr_i = 3'd4;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    @(posedge wb_clk_i); #1;
    checkOutput("rst_mid_ack", wb_ack_o, 0);
    wb_rst_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    applyStimulus(3'd4, 1'b0, 0, 0); checkOutput("rst2_ctrl", last_dat, 32'h0000_0500);
    applyStimulus(3'd2, 1'b0, 0, 0); checkOutput("rst2_cmp_lo", last_dat, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/wb_mtimer.md
WB_MTIMER -- requirements
Module: wb_mtimer

Interface
REQ-001 SHALL have parameter PRESC_RESET, default 8'd0, reset value of CTRL.PRESC.
REQ-002 SHALL have wb_clk_i  input  1  sole clock; all logic is rising-edge.
REQ-003 SHALL have wb_rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have wb_adr_i  input  3  word offset (byte address bits [4:2]).
REQ-005 SHALL have wb_dat_i  input  32  write data.
REQ-006 SHALL have wb_sel_i  input  4  byte enables for writes.
REQ-007 SHALL have wb_we_i  input  1  write strobe qualifier.
REQ-008 SHALL have wb_cyc_i  input  1  bus cycle valid.
REQ-009 SHALL have wb_stb_i  input  1  transfer strobe.
REQ-010 SHALL have wb_dat_o  output  32  read data, valid while wb_ack_o is high.
REQ-011 SHALL have wb_ack_o  output  1  transfer acknowledge.
REQ-012 SHALL have wb_err_o  output  1  error terminate for unmapped offsets.
REQ-013 SHALL have timer_irq_o  output  1  machine-timer interrupt, level.

Function
REQ-014 Register map (offset: reg): 0 MTIME_LO RW, 1 MTIME_HI RW, 2 MTIMECMP_LO RW, 3 MTIMECMP_HI RW, 4 CTRL RW (bit0 EN, bits[15:8] PRESC, others read 0), 5 STATUS RO (bit0 = timer_irq_o); offsets 6-7 unmapped.
REQ-015 Request = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o; terminate (ack or err) is registered, asserted exactly the cycle after the request, high for one cycle only.
REQ-016 Back-to-back requests: held cyc/stb yields terminate every second cycle; a request dropped before its terminate cycle is still terminated once with no side effect repeated.
REQ-017 Writes commit on the request cycle, per byte lane where wb_sel_i bit is 1; wb_sel_i=0 writes nothing but still acks.
REQ-018 Unmapped offsets: wb_err_o instead of wb_ack_o, no state change, wb_dat_o=0.
REQ-019 wb_dat_o is registered with the terminate; it is 0 when not terminating.
REQ-020 Prescaler: 8-bit counter; when EN=1 it counts 0..PRESC then wraps to 0, and the wrap cycle is a tick; PRESC=0 ticks every cycle; EN=0 holds prescaler and mtime.
REQ-021 On a tick mtime (64-bit) increments by 1, wrapping 2^64-1 -> 0.
REQ-022 A write to MTIME_LO or MTIME_HI in a tick cycle wins: written bytes take wb_dat_i, unwritten bytes of the 64-bit value keep their pre-cycle value, no increment that cycle.
REQ-023 Writing CTRL resets the prescaler counter to 0.
REQ-024 Atomic read: reading MTIME_LO returns mtime[31:0] and captures mtime[63:32] into a shadow; reading MTIME_HI returns the shadow, not live mtime[63:32].
REQ-025 timer_irq_o is registered: next value = (mtime >= mtimecmp), 64-bit unsigned, evaluated every cycle regardless of EN; one cycle of latency after any mtime/mtimecmp change.
REQ-026 Reset mid-transfer: outstanding terminate is dropped; master must re-issue.

Reset
REQ-027 On wb_rst_i: mtime=0, shadow=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, EN=0, PRESC=PRESC_RESET, prescaler=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, timer_irq_o=0.

Structure
REQ-028 Package wb_mtimer_pkg SHALL hold register offset constants, CTRL bit positions/field widths and MTIMECMP reset constant.
REQ-029 Prescaler/tick generation SHALL be one sub-module, mtimer_prescaler (inputs en, presc, clr; output tick).

Verification
REQ-030 Reset, read offsets 0-5 -> 0,0,FFFFFFFF,FFFFFFFF,0000_0000 | PRESC_RESET<<8,0; irq=0.
REQ-031 Write CTRL=0x0000_0301, wait 40 cycles -> mtime advances exactly once per 4 cycles (10 +/-1); read MTIME_LO ack arrives one cycle after stb.
REQ-032 Write MTIME_LO=FFFF_FFFF, MTIME_HI=0, EN=1, PRESC=0 -> next tick mtime=0x1_0000_0000; read LO then HI returns 0 and 1 consistently.
REQ-033 MTIMECMP=0x0000_0000_0000_0020, EN=1, PRESC=0 from mtime=0 -> timer_irq_o rises one cycle after mtime reaches 0x20; write MTIMECMP_LO=FFFF_FFFF -> irq falls one cycle later.
REQ-034 Write MTIME_LO with wb_sel_i=4'b0001, data 0xAB, on a tick cycle -> mtime[7:0]=0xAB, other bytes unchanged, no increment.
REQ-035 Access offset 6 (write and read) -> wb_err_o one cycle pulse, wb_ack_o=0, all registers unchanged.
